vec_lane_serializer: RTL and testbench

- Parametrised successor to the fixed 128-bit to 16x8-bit vector unpacker in the SIMD FIR datapath.
- Accepts one packed vector result (LANES x ELEM_W) through a valid/ready handshake and holds it internally.
- Emits the vector one lane per cycle to the scalar audio write-back / sample output path.
- Supports a runtime lane count, selectable lane order, and back-to-back vectors with no bubble.

---
 rtl/simd_pkg.sv | 11 +
 rtl/lane_unpack.sv | 15 +
 rtl/vec_lane_serializer.sv | 98 +++++++++
 tb/tb_vec_lane_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD FIR datapath: default vector geometry and the
// serializer state encoding.
package simd_pkg;
   localparam int LANES_DEF  = 16;
   localparam int ELEM_W_DEF = 8;

   typedef logic [ELEM_W_DEF-1:0] lane_t;
   typedef lane_t [LANES_DEF-1:0] vec_arr_t;

   typedef enum logic {IDLE, STREAM} ser_state_t;
endpackage

// File: rtl/lane_unpack.sv
// Combinational splitter: packed LANES*ELEM_W vector into an array of lanes,
// lane k taken from bits [k*ELEM_W +: ELEM_W].
module lane_unpack
   import simd_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int ELEM_W = ELEM_W_DEF
) (
   input  logic [LANES*ELEM_W-1:0]       i_vec,
   output logic [LANES-1:0][ELEM_W-1:0]  o_lanes
);
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign o_lanes[k] = i_vec[k*ELEM_W +: ELEM_W];
   end
endmodule

// File: rtl/vec_lane_serializer.sv
// Holds one packed vector and streams it out one lane per cycle, with a
// runtime lane count, selectable lane order and bubble-free back-to-back loads.
module vec_lane_serializer
   import simd_pkg::*;
#(
   parameter int LANES     = LANES_DEF,
   parameter int ELEM_W    = ELEM_W_DEF,
   parameter int LSB_FIRST = 1,
   parameter int CNT_W     = $clog2(LANES+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*ELEM_W-1:0]   in_vec,
   input  logic [CNT_W-1:0]          in_count,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ELEM_W-1:0]         out_lane,
   output logic [$clog2(LANES)-1:0]  out_idx,
   output logic                      out_last,
   output logic                      busy
);
   localparam int IDX_W = $clog2(LANES);

   ser_state_t                     r_state, w_state_nx;
   logic [LANES*ELEM_W-1:0]        r_vec;
   logic [CNT_W-1:0]               r_n;
   logic [IDX_W-1:0]               r_cnt;
   logic                           r_rdy_en;
   logic [LANES-1:0][ELEM_W-1:0]   w_lanes;
   logic [IDX_W-1:0]               w_idx;
   logic [CNT_W-1:0]               w_n;
   logic                           w_acc, w_xfer;

   lane_unpack #(.LANES(LANES), .ELEM_W(ELEM_W)) u_unpack (
      .i_vec   (r_vec),
      .o_lanes (w_lanes)
   );

   assign w_xfer   = out_valid && out_ready;
   assign in_ready = r_rdy_en && (!busy || (w_xfer && out_last));
   assign w_acc    = in_valid && in_ready;
   assign w_n      = (in_count == '0 || in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   // Next-state logic; a load on the last-lane transfer keeps us in STREAM
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (w_acc) w_state_nx = STREAM;
         STREAM:  if (w_xfer && out_last && !w_acc) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         STREAM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // in_ready is held low until the first clock after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en <= 1'b0;
         r_vec    <= '0;
         r_n      <= '0;
         r_cnt    <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_acc) begin
            r_vec <= in_vec;
            r_n   <= w_n;
            r_cnt <= '0;
         end else if (w_xfer) begin
            r_cnt <= r_cnt + IDX_W'(1);
         end
      end
   end

   assign w_idx    = (LSB_FIRST != 0) ? r_cnt : IDX_W'(LANES-1) - r_cnt;
   assign out_idx  = busy ? w_idx : '0;
   assign out_lane = busy ? w_lanes[w_idx] : '0;
   assign out_last = busy && (CNT_W'(r_cnt) == r_n - CNT_W'(1));
endmodule

// File: tb/tb_vec_lane_serializer.sv
// Directed bench: two serializers (LSB-first and MSB-first) share one stimulus.
module tb_vec_lane_serializer;
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready, b_in_ready;
   logic [127:0] in_vec;
   logic [4:0]   in_count;
   logic         out_valid, b_out_valid;
   logic         out_ready;
   logic [7:0]   out_lane, b_out_lane;
   logic [3:0]   out_idx, b_out_idx;
   logic         out_last, b_out_last;
   logic         busy, b_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vec_lane_serializer #(.LANES(16), .ELEM_W(8), .LSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .in_count(in_count), .out_valid(out_valid),
      .out_ready(out_ready), .out_lane(out_lane), .out_idx(out_idx),
      .out_last(out_last), .busy(busy)
   );

   vec_lane_serializer #(.LANES(16), .ELEM_W(8), .LSB_FIRST(0)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_vec(in_vec), .in_count(in_count), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_lane(b_out_lane), .out_idx(b_out_idx),
      .out_last(b_out_last), .busy(b_busy)
   );

   function automatic logic [127:0] mk(input logic [7:0] base);
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[k*8 +: 8] = base + 8'(k);
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_count = '0; out_ready = 1'b1;
      #12;
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
          out_lane !== 8'h00 || out_idx !== 4'h0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b last=%b busy=%b lane=%h idx=%0d, want all 0",
                  out_valid, out_last, busy, out_lane, out_idx);
      end
      @(negedge clk); rst = 1'b0;
      cyc();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      in_vec = mk(8'h00); in_count = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL basic_accept: in_ready=%b want 1", in_ready);
      end
      for (int k = 0; k < 16; k++) begin
         cyc();
         in_valid = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b1 || out_lane !== 8'(k) || out_idx !== 4'(k) ||
             out_last !== (k == 15) || in_ready !== (k == 15)) begin
            bad++;
            $display("FAIL basic_lane%0d: v=%b lane=%h idx=%0d last=%b rdy=%b, want 1 %h %0d %b %b",
                     k, out_valid, out_lane, out_idx, out_last, in_ready, 8'(k), k, k == 15, k == 15);
         end
      end
      cyc();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_idle: valid=%b busy=%b want 0/0", out_valid, busy);
      end
   endtask

   task automatic test_msb_first();
      in_vec = mk(8'h00); in_count = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc();
         in_valid = 1'b0;
         #1;
         total++;
         if (b_out_valid !== 1'b1 || b_out_idx !== 4'(15-k) || b_out_lane !== 8'(15-k) ||
             b_out_last !== (k == 15)) begin
            bad++;
            $display("FAIL msb_lane%0d: v=%b idx=%0d lane=%h last=%b, want 1 %0d %h %b",
                     k, b_out_valid, b_out_idx, b_out_lane, b_out_last, 15-k, 8'(15-k), k == 15);
         end
      end
      cyc();
   endtask

   task automatic test_count(input logic [4:0] cnt, input int n);
      in_vec = mk(8'h40); in_count = cnt; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         cyc();
         in_valid = 1'b0; in_count = 5'd1;
         #1;
         total++;
         if (out_valid !== 1'b1 || out_lane !== 8'(8'h40 + k) || out_last !== (k == n-1)) begin
            bad++;
            $display("FAIL count%0d_lane%0d: v=%b lane=%h last=%b, want 1 %h %b",
                     cnt, k, out_valid, out_lane, out_last, 8'(8'h40 + k), k == n-1);
         end
      end
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL count%0d_end: valid=%b want 0", cnt, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      in_vec = mk(8'hA0); in_count = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_vec = mk(8'hB0);
      for (int k = 0; k < 32; k++) begin
         if (k > 0) cyc();
         if (k == 16) in_valid = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b1 ||
             out_lane !== ((k < 16) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 16)) ||
             out_last !== (k == 15 || k == 31)) begin
            bad++;
            $display("FAIL b2b_cycle%0d: v=%b lane=%h last=%b, want 1 %h %b", k, out_valid,
                     out_lane, out_last, (k < 16) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 16),
                     k == 15 || k == 31);
         end
      end
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_end: valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_stall();
      logic [7:0] got[$];
      logic [7:0] s_lane;
      logic [3:0] s_idx;
      logic       s_last, stalled, last_seen;
      int         cyc_n;
      stalled = 1'b0; last_seen = 1'b0; cyc_n = 0;
      s_lane = '0; s_idx = '0; s_last = 1'b0;
      in_vec = mk(8'h30); in_count = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      while (!last_seen && cyc_n < 80) begin
         out_ready = (cyc_n % 4 == 0) || (cyc_n % 4 == 3);
         #1;
         if (stalled) begin
            total++;
            if (out_lane !== s_lane || out_idx !== s_idx || out_last !== s_last) begin
               bad++;
               $display("FAIL stall_hold%0d: lane=%h idx=%0d last=%b, want %h %0d %b",
                        cyc_n, out_lane, out_idx, out_last, s_lane, s_idx, s_last);
            end
         end
         if (out_valid && out_ready) begin
            got.push_back(out_lane);
            last_seen = out_last;
         end
         stalled = !out_ready; s_lane = out_lane; s_idx = out_idx; s_last = out_last;
         cyc_n++;
         cyc();
      end
      out_ready = 1'b1;
      total++;
      if (got.size() != 16 || !last_seen) begin
         bad++; $display("FAIL stall_count: got %0d lanes last=%b, want 16 1", got.size(), last_seen);
      end
      for (int k = 0; k < got.size() && k < 16; k++) begin
         total++;
         if (got[k] !== 8'(8'h30 + k)) begin
            bad++; $display("FAIL stall_sb%0d: lane=%h want %h", k, got[k], 8'(8'h30 + k));
         end
      end
   endtask

   task automatic test_reset_mid();
      in_vec = mk(8'hC0); in_count = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         in_valid = 1'b0;
      end
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_lane !== 8'h00 || out_idx !== 4'h0 ||
          out_last !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_async: v=%b busy=%b lane=%h idx=%0d last=%b, want all 0",
                  out_valid, busy, out_lane, out_idx, out_last);
      end
      cyc();
      @(negedge clk); rst = 1'b0;
      cyc();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_idle: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
      end
      in_vec = mk(8'hD0); in_count = 5'd4; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         in_valid = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b1 || out_lane !== 8'(8'hD0 + k) || out_idx !== 4'(k) ||
             out_last !== (k == 3)) begin
            bad++;
            $display("FAIL rstmid_lane%0d: v=%b lane=%h idx=%0d last=%b, want 1 %h %0d %b",
                     k, out_valid, out_lane, out_idx, out_last, 8'(8'hD0 + k), k, k == 3);
         end
      end
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_end: valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_msb_first();
      test_count(5'd3, 3);
      test_count(5'd20, 16);
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish before 200000");
      $fatal(1);
   end
endmodule
